// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer and its detector.
// The cop0 record layout lives here so the detector, the sequencer and cop0 all agree on it.
package exc_seq_pkg;

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_COMMIT, S_REDIRECT} seq_state_t;
   typedef enum logic [1:0] {K_EXC, K_INT, K_ERET} seq_kind_t;

   typedef struct packed {
      logic        exception_happen;
      logic [4:0]  exc_code;
      logic [31:0] epc;
      logic        in_bd;
      logic [31:0] badvaddr;
      logic        load_addr;
   } cop0_exc_data_t;

   localparam logic [4:0] EXCCODE_INT  = 5'h00;
   localparam logic [4:0] EXCCODE_MOD  = 5'h01;
   localparam logic [4:0] EXCCODE_TLBL = 5'h02;
   localparam logic [4:0] EXCCODE_TLBS = 5'h03;
   localparam logic [4:0] EXCCODE_ADEL = 5'h04;
   localparam logic [4:0] EXCCODE_ADES = 5'h05;
   localparam logic [4:0] EXCCODE_SYS  = 5'h08;
   localparam logic [4:0] EXCCODE_BP   = 5'h09;
   localparam logic [4:0] EXCCODE_RI   = 5'h0A;
   localparam logic [4:0] EXCCODE_CPU  = 5'h0B;
   localparam logic [4:0] EXCCODE_OV   = 5'h0C;
   localparam logic [4:0] EXCCODE_TR   = 5'h0D;

   localparam int STATUS_IE     = 0;
   localparam int STATUS_EXL    = 1;
   localparam int STATUS_ERL    = 2;
   localparam int STATUS_IM_LSB = 8;
   localparam int STATUS_BEV    = 22;

   // Interrupts never carry a bad address; the restart PC comes from execute.
   function automatic cop0_exc_data_t int_record(input logic [31:0] epc, input logic in_bd);
      cop0_exc_data_t r;
      r                  = '0;
      r.exception_happen = 1'b1;
      r.exc_code         = EXCCODE_INT;
      r.epc              = epc;
      r.in_bd            = in_bd;
      return r;
   endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Pipeline-facing bundle of the exception sequencer: detector inputs, cop0 commit, fetch redirect.
interface exception_sequencer_if
   import exc_seq_pkg::*;
#(parameter int INT_LINES = 8);

   cop0_exc_data_t         exc_in;
   logic [31:0]            exc_vector;
   logic [INT_LINES-1:0]   int_req;
   logic [31:0]            status;
   logic [31:0]            cur_epc;
   logic [31:0]            int_epc;
   logic                   int_in_bd;
   logic                   eret_req;
   logic                   mem_busy;
   logic                   redirect_ready;
   logic                   stall;
   logic                   flush;
   logic                   cop0_we;
   cop0_exc_data_t         cop0_wdata;
   logic                   cop0_eret;
   logic                   redirect_valid;
   logic [31:0]            redirect_pc;
   logic                   busy;

   modport slave (
      input  exc_in, exc_vector, int_req, status, cur_epc, int_epc, int_in_bd,
             eret_req, mem_busy, redirect_ready,
      output stall, flush, cop0_we, cop0_wdata, cop0_eret, redirect_valid, redirect_pc, busy
   );

   modport master (
      output exc_in, exc_vector, int_req, status, cur_epc, int_epc, int_in_bd,
             eret_req, mem_busy, redirect_ready,
      input  stall, flush, cop0_we, cop0_wdata, cop0_eret, redirect_valid, redirect_pc, busy
   );

endinterface

// File: rtl/exception_sequencer_irq_gate.sv
// Interrupt masking: a line is taken only when enabled in IM and the core is not at EXL/ERL.
module exception_irq_gate #(
   parameter int INT_LINES = 8
) (
   input  logic [INT_LINES-1:0] i_int_req,
   input  logic [INT_LINES-1:0] i_im,
   input  logic                 i_ie,
   input  logic                 i_exl,
   input  logic                 i_erl,
   output logic [INT_LINES-1:0] o_ip_vector,
   output logic                 o_int_pending
);

   // Cause.IP reflects the raw lines regardless of masking.
   assign o_ip_vector   = i_int_req;
   assign o_int_pending = (|(i_int_req & i_im)) & i_ie & ~i_exl & ~i_erl;

endmodule

// File: rtl/exception_sequencer.sv
// Multi-cycle exception/interrupt/ERET sequencer: flush, drain memory, commit cop0, redirect fetch.
module exception_sequencer
   import exc_seq_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int INT_LINES    = 8
) (
   input logic                   clk,
   input logic                   reset_n,
   exception_sequencer_if.slave  bus
);

   localparam int FC_EFF = (FLUSH_CYCLES < 1) ? 1 : FLUSH_CYCLES;
   localparam int CNT_W  = $clog2(FC_EFF + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FC_EFF - 1);

   seq_state_t       r_state, w_state_nxt;
   seq_kind_t        r_kind, w_kind;
   cop0_exc_data_t   r_rec, w_rec;
   logic [31:0]      r_target, w_target;
   logic [CNT_W-1:0] r_cnt;
   logic             w_event, w_int_pending;
   logic [INT_LINES-1:0] w_ip_vector;

   exception_irq_gate #(.INT_LINES(INT_LINES)) u_irq_gate (
      .i_int_req     (bus.int_req),
      .i_im          (bus.status[STATUS_IM_LSB +: INT_LINES]),
      .i_ie          (bus.status[STATUS_IE]),
      .i_exl         (bus.status[STATUS_EXL]),
      .i_erl         (bus.status[STATUS_ERL]),
      .o_ip_vector   (w_ip_vector),
      .o_int_pending (w_int_pending)
   );

   // Fixed priority: exception, then interrupt, then ERET; losers re-present later.
   always_comb begin
      w_event  = 1'b1;
      w_kind   = K_EXC;
      w_rec    = bus.exc_in;
      w_target = bus.exc_vector;
      if (!bus.exc_in.exception_happen) begin
         if (w_int_pending) begin
            w_kind = K_INT;
            w_rec  = int_record(bus.int_epc, bus.int_in_bd);
         end else if (bus.eret_req) begin
            w_kind   = K_ERET;
            w_rec    = '0;
            w_target = bus.cur_epc;
         end else begin
            w_event = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_kind   <= K_EXC;
         r_rec    <= '0;
         r_target <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_IDLE && w_event) begin
         r_kind   <= w_kind;
         r_rec    <= w_rec;
         r_target <= w_target;
         r_cnt    <= '0;
      end else if (r_state == S_FLUSH && r_cnt != '1) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:     if (w_event) w_state_nxt = S_FLUSH;
         S_FLUSH:    if (r_cnt >= CNT_LAST && !bus.mem_busy) w_state_nxt = S_COMMIT;
         S_COMMIT:   w_state_nxt = S_REDIRECT;
         S_REDIRECT: if (bus.redirect_ready) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode the registered state, so they rise the cycle after the event.
   always_comb begin
      bus.stall          = 1'b0;
      bus.flush          = 1'b0;
      bus.cop0_we        = 1'b0;
      bus.cop0_wdata     = '0;
      bus.cop0_eret      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.busy           = 1'b0;
      unique case (r_state)
         S_FLUSH: begin
            bus.stall = 1'b1;
            bus.flush = 1'b1;
            bus.busy  = 1'b1;
         end
         S_COMMIT: begin
            bus.stall      = 1'b1;
            bus.busy       = 1'b1;
            bus.cop0_we    = 1'b1;
            bus.cop0_wdata = r_rec;
            bus.cop0_eret  = (r_kind == K_ERET);
         end
         S_REDIRECT: begin
            bus.stall          = 1'b1;
            bus.busy           = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = r_target;
         end
         default: ;
      endcase
   end

   a_ip_consistent: assert property (@(posedge clk) disable iff (!reset_n)
      w_int_pending |-> (|w_ip_vector));

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer: expected commits/redirects queued at stimulus time.
module tb_exception_sequencer;
   import exc_seq_pkg::*;

   typedef struct { cop0_exc_data_t rec; logic eret; } exp_commit_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   exception_sequencer_if #(.INT_LINES(8)) bus ();
   exception_sequencer #(.FLUSH_CYCLES(2), .INT_LINES(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_commit_t q_commit[$];
   logic [31:0] q_redir[$];
   exp_commit_t m_e;
   logic [31:0] m_pc;
   int n_pass = 0;
   int n_total = 0;

   function automatic cop0_exc_data_t mk(input logic hap, input logic [4:0] code, input logic [31:0] epc,
                                         input logic bd, input logic [31:0] bva, input logic la);
      cop0_exc_data_t r;
      r.exception_happen = hap; r.exc_code = code; r.epc = epc;
      r.in_bd = bd; r.badvaddr = bva; r.load_addr = la;
      return r;
   endfunction

   // Scoreboard: every commit and every accepted redirect must match the queued expectation.
   always @(negedge clk) begin
      if (reset_n && bus.cop0_we) begin
         n_total++;
         if (q_commit.size() == 0) $display("FAIL commit_unexpected: cop0_we=1 wdata=%h, none expected", bus.cop0_wdata);
         else begin
            m_e = q_commit.pop_front();
            if (bus.cop0_wdata !== m_e.rec || bus.cop0_eret !== m_e.eret)
               $display("FAIL commit_data: got wdata=%h eret=%b want wdata=%h eret=%b",
                        bus.cop0_wdata, bus.cop0_eret, m_e.rec, m_e.eret);
            else n_pass++;
         end
      end
      if (reset_n && bus.redirect_valid && bus.redirect_ready) begin
         n_total++;
         if (q_redir.size() == 0) $display("FAIL redirect_unexpected: pc=%h, none expected", bus.redirect_pc);
         else begin
            m_pc = q_redir.pop_front();
            if (bus.redirect_pc !== m_pc) $display("FAIL redirect_pc: got %h want %h", bus.redirect_pc, m_pc);
            else n_pass++;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      bus.exc_in = '0; bus.exc_vector = '0; bus.int_req = '0; bus.status = '0;
      bus.cur_epc = '0; bus.int_epc = '0; bus.int_in_bd = 1'b0; bus.eret_req = 1'b0;
      bus.mem_busy = 1'b0; bus.redirect_ready = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40 && bus.busy; i++) step();
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL %s_timeout: busy=%b after 40 cycles want 0", name, bus.busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 reset_n = 1'b0;
      #10;
      n_total++;
      if ({bus.busy, bus.stall, bus.flush, bus.cop0_we, bus.cop0_eret, bus.redirect_valid} !== 6'b0)
         $display("FAIL reset_ctrl: busy/stall/flush/we/eret/valid=%b want 000000",
                  {bus.busy, bus.stall, bus.flush, bus.cop0_we, bus.cop0_eret, bus.redirect_valid});
      else n_pass++;
      n_total++;
      if (bus.redirect_pc !== 32'h0 || bus.cop0_wdata !== '0)
         $display("FAIL reset_data: pc=%h wdata=%h want 0", bus.redirect_pc, bus.cop0_wdata);
      else n_pass++;
      @(negedge clk) reset_n = 1'b1;
      step();
   endtask

   task automatic test_overflow();
      bus.exc_in = mk(1'b1, 5'hC, 32'h0040_0010, 1'b0, 32'hDEAD_BEEF, 1'b0);
      bus.exc_vector = 32'h8000_0180;
      q_commit.push_back('{mk(1'b1, 5'hC, 32'h0040_0010, 1'b0, 32'hDEAD_BEEF, 1'b0), 1'b0});
      q_redir.push_back(32'h8000_0180);
      step();  // T+1
      bus.exc_in = '0;
      n_total++;
      if ({bus.busy, bus.stall, bus.flush, bus.cop0_we} !== 4'b1110)
         $display("FAIL ovf_t1: busy/stall/flush/we=%b want 1110", {bus.busy, bus.stall, bus.flush, bus.cop0_we});
      else n_pass++;
      step();  // T+2
      n_total++;
      if ({bus.flush, bus.cop0_we} !== 2'b10) $display("FAIL ovf_t2: flush/we=%b want 10", {bus.flush, bus.cop0_we});
      else n_pass++;
      step();  // T+3
      n_total++;
      if ({bus.flush, bus.cop0_we, bus.stall} !== 3'b011)
         $display("FAIL ovf_t3: flush/we/stall=%b want 011", {bus.flush, bus.cop0_we, bus.stall});
      else n_pass++;
      step();  // T+4
      n_total++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h8000_0180 || bus.cop0_we !== 1'b0)
         $display("FAIL ovf_t4: valid=%b pc=%h we=%b want 1 80000180 0", bus.redirect_valid, bus.redirect_pc, bus.cop0_we);
      else n_pass++;
      step();  // T+5
      n_total++;
      if ({bus.busy, bus.stall, bus.redirect_valid} !== 3'b000)
         $display("FAIL ovf_t5: busy/stall/valid=%b want 000", {bus.busy, bus.stall, bus.redirect_valid});
      else n_pass++;
   endtask

   task automatic test_tie();
      bus.status = 32'h0000_0401;
      bus.int_req = 8'h04; bus.int_epc = 32'h0040_0200; bus.int_in_bd = 1'b1;
      bus.exc_in = mk(1'b1, 5'h8, 32'h0040_0020, 1'b0, 32'h0, 1'b0);
      bus.exc_vector = 32'h8000_0180;
      q_commit.push_back('{mk(1'b1, 5'h8, 32'h0040_0020, 1'b0, 32'h0, 1'b0), 1'b0});
      q_redir.push_back(32'h8000_0180);
      q_commit.push_back('{mk(1'b1, 5'h0, 32'h0040_0200, 1'b1, 32'h0, 1'b0), 1'b0});
      q_redir.push_back(32'h8000_0180);
      step();
      bus.exc_in = '0;
      wait_idle("tie_exc");
      step();
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL tie_int_taken: busy=%b want 1", bus.busy);
      else n_pass++;
      bus.int_req = '0; bus.status = '0;
      wait_idle("tie_int");
   endtask

   task automatic test_drain();
      bus.exc_in = mk(1'b1, 5'h4, 32'h0040_0030, 1'b0, 32'h1000_0003, 1'b1);
      bus.exc_vector = 32'h8000_0180;
      q_commit.push_back('{mk(1'b1, 5'h4, 32'h0040_0030, 1'b0, 32'h1000_0003, 1'b1), 1'b0});
      q_redir.push_back(32'h8000_0180);
      step();
      bus.exc_in = '0;
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_total++;
         if ({bus.stall, bus.flush, bus.cop0_we} !== 3'b110)
            $display("FAIL drain_hold%0d: stall/flush/we=%b want 110", i, {bus.stall, bus.flush, bus.cop0_we});
         else n_pass++;
      end
      bus.mem_busy = 1'b0;
      step();
      n_total++;
      if (bus.cop0_we !== 1'b1) $display("FAIL drain_commit: cop0_we=%b want 1", bus.cop0_we);
      else n_pass++;
      wait_idle("drain");
   endtask

   task automatic test_eret();
      bus.status = 32'h0000_0002; bus.cur_epc = 32'h0040_0100;
      bus.eret_req = 1'b1; bus.redirect_ready = 1'b0;
      q_commit.push_back('{cop0_exc_data_t'('0), 1'b1});
      q_redir.push_back(32'h0040_0100);
      step();
      bus.eret_req = 1'b0;
      step(); step();
      n_total++;
      if (bus.cop0_we !== 1'b1 || bus.cop0_eret !== 1'b1)
         $display("FAIL eret_commit: we=%b eret=%b want 1 1", bus.cop0_we, bus.cop0_eret);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) bus.redirect_ready = 1'b0;
         step();
         n_total++;
         if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0040_0100)
            $display("FAIL eret_hold%0d: valid=%b pc=%h want 1 00400100", i, bus.redirect_valid, bus.redirect_pc);
         else n_pass++;
      end
      bus.redirect_ready = 1'b1;
      step();
      n_total++;
      if ({bus.busy, bus.redirect_valid} !== 2'b00)
         $display("FAIL eret_done: busy/valid=%b want 00", {bus.busy, bus.redirect_valid});
      else n_pass++;
      bus.status = '0;
   endtask

   task automatic test_back_to_back();
      bus.exc_in = mk(1'b1, 5'hA, 32'h0040_0040, 1'b1, 32'h0, 1'b0);
      bus.exc_vector = 32'h8000_0200;
      q_commit.push_back('{mk(1'b1, 5'hA, 32'h0040_0040, 1'b1, 32'h0, 1'b0), 1'b0});
      q_redir.push_back(32'h8000_0200);
      step();
      bus.exc_in = mk(1'b1, 5'h9, 32'h0040_0044, 1'b0, 32'h0, 1'b0);
      bus.eret_req = 1'b1; bus.cur_epc = 32'h0000_1234;
      step(); step(); step();
      idle_inputs();
      wait_idle("b2b");
      for (int i = 0; i < 3; i++) step();
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL b2b_ignored: busy=%b want 0", bus.busy);
      else n_pass++;
   endtask

   task automatic test_mask();
      logic [31:0] st [4];
      st[0] = 32'h0000_FF03; st[1] = 32'h0000_FF00; st[2] = 32'h0000_FF05; st[3] = 32'h0000_0001;
      bus.int_req = 8'hFF; bus.int_epc = 32'h0040_0300; bus.int_in_bd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.status = st[k];
         step(); step(); step();
         n_total++;
         if (bus.busy !== 1'b0) $display("FAIL mask%0d: busy=%b want 0 status=%h", k, bus.busy, st[k]);
         else n_pass++;
      end
      bus.status = 32'h0000_FF01;
      q_commit.push_back('{mk(1'b1, 5'h0, 32'h0040_0300, 1'b0, 32'h0, 1'b0), 1'b0});
      q_redir.push_back(32'h8000_0180);
      bus.exc_vector = 32'h8000_0180;
      step();
      bus.int_req = '0; bus.status = '0;
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL mask_enabled: busy=%b want 1", bus.busy);
      else n_pass++;
      wait_idle("mask");
   endtask

   task automatic test_abort();
      logic seen;
      bus.exc_in = mk(1'b1, 5'hC, 32'h0040_0050, 1'b0, 32'h0, 1'b0);
      bus.exc_vector = 32'h8000_0180;
      step();
      bus.exc_in = '0;
      step(); step();
      n_total++;
      if (bus.cop0_we !== 1'b1) $display("FAIL abort_in_commit: cop0_we=%b want 1", bus.cop0_we);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({bus.busy, bus.stall, bus.flush, bus.cop0_we, bus.redirect_valid} !== 5'b0 || bus.cop0_wdata !== '0)
         $display("FAIL abort_async: busy/stall/flush/we/valid=%b wdata=%h want 0",
                  {bus.busy, bus.stall, bus.flush, bus.cop0_we, bus.redirect_valid}, bus.cop0_wdata);
      else n_pass++;
      step();
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.busy !== 1'b0 || bus.cop0_we !== 1'b0) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL abort_after: activity=%b after release want 0", seen);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_tie();
      test_drain();
      test_eret();
      test_back_to_back();
      test_mask();
      test_abort();
      n_total++;
      if (q_commit.size() != 0 || q_redir.size() != 0)
         $display("FAIL scoreboard_drain: %0d commits %0d redirects left want 0 0", q_commit.size(), q_redir.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
